// File: rtl/m2_block_scheduler_if.sv
// Handshake and address bundle between the IDCT block scheduler and its
// four sub-units: fetch S' (FS), compute T (CT), compute S (CS), write S (WS).
interface m2_block_scheduler_if;
  // Single-cycle start pulses from the scheduler
  logic       start_FS;
  logic       start_CT;
  logic       start_CS;
  logic       start_WS;
  // Single-cycle completion pulses from the sub-units
  logic       done_FS;
  logic       done_CT;
  logic       done_CS;
  logic       done_WS;
  // Block address of the fetch and write streams
  logic [1:0] fs_seg;
  logic [4:0] fs_row;
  logic [5:0] fs_col;
  logic [1:0] ws_seg;
  logic [4:0] ws_row;
  logic [5:0] ws_col;
  // Shared multiplier owner: 0 = CT, 1 = CS
  logic       mult_sel;

  modport master (
    output start_FS, start_CT, start_CS, start_WS,
    output fs_seg, fs_row, fs_col, ws_seg, ws_row, ws_col, mult_sel,
    input  done_FS, done_CT, done_CS, done_WS
  );

  modport slave (
    input  start_FS, start_CT, start_CS, start_WS,
    input  fs_seg, fs_row, fs_col, ws_seg, ws_row, ws_col, mult_sel,
    output done_FS, done_CT, done_CS, done_WS
  );
endinterface

// File: rtl/m2_block_scheduler.sv
// Top-level IDCT sequencer. Walks every 8x8 block of the Y, U and V segments
// and overlaps sub-unit work: CS of block n runs with FS of block n+1, then
// CT of block n+1 runs with WS of block n. Each phase is a GO cycle that
// pulses the starts, followed by a WAIT that collects the matching dones.
module m2_block_scheduler #(
  parameter int Y_COLS  = 40,
  parameter int UV_COLS = 20,
  parameter int ROWS    = 30
) (
  input  logic                   CLOCK_50,
  input  logic                   Resetn,
  input  logic                   Start,
  m2_block_scheduler_if.master   su,
  output logic                   busy,
  output logic                   Done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LI_FS_GO, S_LI_FS_WAIT,
    S_LI_CT_GO, S_LI_CT_WAIT,
    S_MA_GO,    S_MA_WAIT,
    S_MB_GO,    S_MB_WAIT,
    S_LO_GO,    S_LO_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] seg;
    logic [4:0] row;
    logic [5:0] col;
  } blk_t;

  // Unit bit positions in start/need/flag vectors: {WS, CS, CT, FS}
  localparam logic [3:0] M_FS = 4'b0001;
  localparam logic [3:0] M_CT = 4'b0010;
  localparam logic [3:0] M_CS = 4'b0100;
  localparam logic [3:0] M_WS = 4'b1000;

  localparam logic [5:0] Y_CMAX  = 6'(Y_COLS - 1);
  localparam logic [5:0] UV_CMAX = 6'(UV_COLS - 1);
  localparam logic [4:0] R_MAX   = 5'(ROWS - 1);

  // Raster order: column first, then row, then segment (Y=0, U=1, V=2)
  function automatic blk_t next_blk(input blk_t b);
    blk_t n;
    n = b;
    if (b.col == ((b.seg == 2'd0) ? Y_CMAX : UV_CMAX)) begin
      n.col = '0;
      if (b.row == R_MAX) begin
        n.row = '0;
        n.seg = b.seg + 2'd1;
      end else begin
        n.row = b.row + 5'd1;
      end
    end else begin
      n.col = b.col + 6'd1;
    end
    return n;
  endfunction

  function automatic logic is_last(input blk_t b);
    return (b.seg == 2'd2) && (b.row == R_MAX) && (b.col == UV_CMAX);
  endfunction

  state_t     r_state;
  logic [3:0] r_start;     // start pulses, one bit per unit
  logic [3:0] r_need;      // units started in the current phase
  logic [3:0] r_flag;      // units of the current phase that have finished
  blk_t       r_fs;
  blk_t       r_ws;
  logic       r_last;      // final block has been fetched
  logic       r_mult_sel;
  logic       r_busy;
  logic       r_done;

  logic [3:0] w_done;
  logic       w_wait;
  logic [3:0] w_accept;
  logic       w_phase_done;

  assign w_done = {su.done_WS, su.done_CS, su.done_CT, su.done_FS};
  assign w_wait = (r_state == S_LI_FS_WAIT) || (r_state == S_LI_CT_WAIT) ||
                  (r_state == S_MA_WAIT)    || (r_state == S_MB_WAIT)    ||
                  (r_state == S_LO_WAIT);
  // Only the first done of a unit started in this phase is taken
  assign w_accept     = w_done & r_need & ~r_flag & {4{w_wait}};
  assign w_phase_done = &(r_flag | ~r_need);

  assign su.start_FS = r_start[0];
  assign su.start_CT = r_start[1];
  assign su.start_CS = r_start[2];
  assign su.start_WS = r_start[3];
  assign su.fs_seg   = r_fs.seg;
  assign su.fs_row   = r_fs.row;
  assign su.fs_col   = r_fs.col;
  assign su.ws_seg   = r_ws.seg;
  assign su.ws_row   = r_ws.row;
  assign su.ws_col   = r_ws.col;
  assign su.mult_sel = r_mult_sel;
  assign busy        = r_busy;
  assign Done        = r_done;

  // Phase sequencer: state, done collection, block counters and outputs
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= S_IDLE;
      r_start    <= '0;
      r_need     <= '0;
      r_flag     <= '0;
      r_fs       <= '0;
      r_ws       <= '0;
      r_last     <= 1'b0;
      r_mult_sel <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: defaults first so pulses drop after one cycle unless re-armed.
      r_start <= '0;
      r_done  <= 1'b0;
      r_flag  <= r_flag | w_accept;

      if (w_accept[0]) begin
        if (is_last(r_fs)) r_last <= 1'b1;
        else               r_fs   <= next_blk(r_fs);
      end
      if (w_accept[3] && !is_last(r_ws)) r_ws <= next_blk(r_ws);

      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_fs    <= '0;
            r_ws    <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
            r_start <= M_FS;
            r_need  <= M_FS;
            r_flag  <= '0;
            r_state <= S_LI_FS_GO;
          end
        end
        S_LI_FS_GO: r_state <= S_LI_FS_WAIT;
        S_LI_FS_WAIT: begin
          if (w_phase_done) begin
            r_start    <= M_CT;
            r_need     <= M_CT;
            r_flag     <= '0;
            r_mult_sel <= 1'b0;
            r_state    <= S_LI_CT_GO;
          end
        end
        S_LI_CT_GO: r_state <= S_LI_CT_WAIT;
        S_LI_CT_WAIT, S_MB_WAIT: begin
          if (w_phase_done) begin
            r_start    <= r_last ? M_CS : (M_CS | M_FS);
            r_need     <= r_last ? M_CS : (M_CS | M_FS);
            r_flag     <= '0;
            r_mult_sel <= 1'b1;
            r_state    <= S_MA_GO;
          end
        end
        S_MA_GO: r_state <= S_MA_WAIT;
        S_MA_WAIT: begin
          if (w_phase_done) begin
            r_flag <= '0;
            if (!r_need[0]) begin
              // CS-only phase: final write-out, multiplier owner unchanged
              r_start <= M_WS;
              r_need  <= M_WS;
              r_state <= S_LO_GO;
            end else begin
              r_start    <= M_CT | M_WS;
              r_need     <= M_CT | M_WS;
              r_mult_sel <= 1'b0;
              r_state    <= S_MB_GO;
            end
          end
        end
        S_MB_GO: r_state <= S_MB_WAIT;
        S_LO_GO: r_state <= S_LO_WAIT;
        S_LO_WAIT: begin
          if (w_phase_done) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Self-checking bench for m2_block_scheduler on a 4-block image
// (Y_COLS=2, UV_COLS=1, ROWS=1). A responder returns each done a fixed
// number of cycles after its start; a monitor pops expected phases and
// addresses from scoreboard queues as start pulses appear.
module tb_m2_block_scheduler;
  localparam int Y_COLS  = 2;
  localparam int UV_COLS = 1;
  localparam int ROWS    = 1;
  localparam int NBLK    = 4;

  typedef struct {
    logic [3:0] mask;
    int         msel;   // -1 where mult_sel is not defined
  } phase_t;

  logic CLOCK_50 = 1'b0;
  logic Resetn   = 1'b0;
  logic Start    = 1'b0;
  logic busy;
  logic Done;

  m2_block_scheduler_if bus();

  m2_block_scheduler #(
    .Y_COLS (Y_COLS),
    .UV_COLS(UV_COLS),
    .ROWS   (ROWS)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Resetn  (Resetn),
    .Start   (Start),
    .su      (bus.master),
    .busy    (busy),
    .Done    (Done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- sub-unit responder ----------------
  int         dly[4] = '{5, 5, 5, 5};
  int         cnt[4] = '{0, 0, 0, 0};
  logic [3:0] inj = 4'b0;
  logic [3:0] done_drv = 4'b0;
  logic [3:0] starts;
  logic [3:0] dones;

  assign starts = {bus.start_WS, bus.start_CS, bus.start_CT, bus.start_FS};
  assign dones  = {bus.done_WS, bus.done_CS, bus.done_CT, bus.done_FS};
  assign bus.done_FS = done_drv[0];
  assign bus.done_CT = done_drv[1];
  assign bus.done_CS = done_drv[2];
  assign bus.done_WS = done_drv[3];

  always @(negedge CLOCK_50) begin
    for (int u = 0; u < 4; u++) begin
      done_drv[u] = inj[u];
      if (starts[u]) cnt[u] = dly[u];
      else if (cnt[u] > 0) begin
        cnt[u] = cnt[u] - 1;
        if (cnt[u] == 0) done_drv[u] = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          cyc = 0;
  int          last_done_cyc = 0;
  int          both_ct_ws = 0;
  int          n_start[4] = '{0, 0, 0, 0};
  int          n_done_seen = 0;
  phase_t      exp_ph[$];
  logic [12:0] exp_fs[$];
  logic [12:0] exp_ws[$];

  always @(posedge CLOCK_50) begin
    cyc = cyc + 1;
    if (|dones) last_done_cyc = cyc;
    if (bus.done_CT && bus.done_WS) both_ct_ws++;
  end

  always @(negedge CLOCK_50) begin
    phase_t p;
    if (Done) n_done_seen++;
    if (|starts) begin
      if (exp_ph.size() == 0) begin
        check("phase_unexpected", 32'(starts), 32'h0);
      end else begin
        p = exp_ph.pop_front();
        check("phase_mask", 32'(starts), 32'(p.mask));
        if (p.msel >= 0) check("mult_sel", 32'(bus.mult_sel), 32'(p.msel));
        // A start is seen by its unit two cycles after the last done pulse
        if (p.mask != 4'b0001) check("start_gap", 32'(cyc + 1 - last_done_cyc), 32'd2);
      end
      for (int u = 0; u < 4; u++) if (starts[u]) n_start[u]++;
      if (starts[0]) begin
        if (exp_fs.size() == 0) check("fs_unexpected", 32'(starts), 32'h0);
        else check("fs_addr", 32'({bus.fs_seg, bus.fs_row, bus.fs_col}), 32'(exp_fs.pop_front()));
      end
      if (starts[3]) begin
        if (exp_ws.size() == 0) check("ws_unexpected", 32'(starts), 32'h0);
        else check("ws_addr", 32'({bus.ws_seg, bus.ws_row, bus.ws_col}), 32'(exp_ws.pop_front()));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_expect();
    logic [3:0]  masks[10] = '{4'h1, 4'h2, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h4, 4'h8};
    int          msels[10] = '{-1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    // (seg,row,col) = (0,0,0) (0,0,1) (1,0,0) (2,0,0)
    logic [12:0] addrs[4]  = '{{2'd0, 5'd0, 6'd0}, {2'd0, 5'd0, 6'd1},
                               {2'd1, 5'd0, 6'd0}, {2'd2, 5'd0, 6'd0}};
    exp_ph.delete();
    exp_fs.delete();
    exp_ws.delete();
    for (int i = 0; i < 10; i++) exp_ph.push_back('{masks[i], msels[i]});
    for (int i = 0; i < 4; i++) begin
      exp_fs.push_back(addrs[i]);
      exp_ws.push_back(addrs[i]);
    end
    for (int u = 0; u < 4; u++) n_start[u] = 0;
    n_done_seen = 0;
    both_ct_ws  = 0;
  endtask

  task automatic pulse_start();
    @(posedge CLOCK_50);
    #1 Start = 1'b1;
    @(posedge CLOCK_50);
    #1 Start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic inject(input logic [3:0] mask);
    @(posedge CLOCK_50);
    #1 inj = mask;
    @(negedge CLOCK_50);
    #1 inj = 4'b0;
  endtask

  task automatic wait_start_count(input string tag, input int u, input int n);
    int i = 0;
    while (n_start[u] < n && i < 2000) begin
      @(negedge CLOCK_50);
      i++;
    end
    check(tag, 32'(n_start[u] >= n), 32'd1);
  endtask

  task automatic finish_pass(input string tag);
    int i = 0;
    while (n_done_seen == 0 && i < 3000) begin
      @(negedge CLOCK_50);
      i++;
    end
    repeat (6) @(negedge CLOCK_50);
    check({tag, "_done_pulses"}, 32'(n_done_seen), 32'd1);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_phases_left"}, 32'(exp_ph.size()), 32'd0);
    check({tag, "_fs_left"}, 32'(exp_fs.size()), 32'd0);
    check({tag, "_ws_left"}, 32'(exp_ws.size()), 32'd0);
    check({tag, "_n_fs"}, 32'(n_start[0]), 32'(NBLK));
    check({tag, "_n_ct"}, 32'(n_start[1]), 32'(NBLK));
    check({tag, "_n_cs"}, 32'(n_start[2]), 32'(NBLK));
    check({tag, "_n_ws"}, 32'(n_start[3]), 32'(NBLK));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_starts"}, 32'(starts), 32'h0);
    check({tag, "_fs"}, 32'({bus.fs_seg, bus.fs_row, bus.fs_col}), 32'h0);
    check({tag, "_ws"}, 32'({bus.ws_seg, bus.ws_row, bus.ws_col}), 32'h0);
    check({tag, "_mult_sel"}, 32'(bus.mult_sel), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_Done"}, 32'(Done), 32'h0);
  endtask

  // Watchdog: the bench must always end on its own
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    Resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_outputs_zero("reset");
    Resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    // Clean pass: phase order, address traces, counts, coincident CT/WS dones
    load_expect();
    pulse_start();
    finish_pass("clean");
    check("clean_ct_ws_same_cycle", 32'(both_ct_ws), 32'd3);

    // Spurious done_FS in idle, spurious done_WS in LI_CT, Start while busy
    load_expect();
    inject(4'b0001);
    repeat (3) @(negedge CLOCK_50);
    pulse_start();
    wait_start_count("noise_ct_started", 1, 1);
    inject(4'b1000);
    pulse_start();
    finish_pass("noise");

    // Slow fetch: done_CS 20 cycles ahead of done_FS in every full MEGA_A
    dly[0] = 25;
    load_expect();
    pulse_start();
    finish_pass("slow_fs");
    dly[0] = 5;

    // Reset during MEGA_B of block 2, then a fresh pass from block (0,0,0)
    load_expect();
    pulse_start();
    wait_start_count("abort_mb2_reached", 3, 2);
    repeat (2) @(negedge CLOCK_50);
    Resetn = 1'b0;
    #1;
    check_outputs_zero("abort");
    @(negedge CLOCK_50);
    Resetn = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    check("abort_stays_idle", 32'(busy), 32'd0);
    load_expect();
    pulse_start();
    finish_pass("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
